// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared defaults, types and address helper for the register file
package pkg_config;
    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGISTER  = 32;
    localparam int REG_AW        = $clog2(NUM_REGISTER);
    localparam int NUM_READ_DEF  = 2;
    localparam int NUM_WRITE_DEF = 1;

    typedef logic [REG_AW-1:0]     reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    // x0 and addresses beyond the populated range are never read, written or reserved.
    function automatic logic addr_legal(input int unsigned addr, input int unsigned num_reg);
        return (addr != 0) && (addr < num_reg);
    endfunction
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// rtl/reg_file_mp_scoreboard.sv - per-register pending bits, set/clear priority and busy lookup
module reg_scoreboard #(
    parameter int NUM_REGISTER = 32,
    parameter int NUM_READ     = 2,
    parameter int NUM_WRITE    = 1,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_WRITE-1:0]          wr_ok_i,
    input  logic [NUM_WRITE-1:0][AW-1:0]  wr_addr_i,
    input  logic                          rsv_i,
    input  logic [AW-1:0]                 rsv_addr_i,
    input  logic [NUM_READ-1:0][AW-1:0]   rs_addr_i,
    input  logic [NUM_READ-1:0]           byp_hit_i,
    output logic [NUM_READ-1:0]           busy_o,
    output logic [NUM_REGISTER-1:0]       pending_o
);
    import pkg_config::*;

    logic [NUM_REGISTER-1:0] pending_q;
    logic [NUM_REGISTER-1:0] pending_d;

    // Reserve is applied after the clears: a new producer supersedes the completing one.
    always_comb begin
        pending_d = pending_q;
        for (int p = 0; p < NUM_WRITE; p++) begin
            if (wr_ok_i[p]) pending_d[wr_addr_i[p]] = 1'b0;
        end
        if (rsv_i && addr_legal(32'(rsv_addr_i), NUM_REGISTER)) pending_d[rsv_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    always_comb begin
        busy_o = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if (addr_legal(32'(rs_addr_i[r]), NUM_REGISTER) && !byp_hit_i[r])
                busy_o[r] = pending_q[rs_addr_i[r]];
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with optional write bypass and scoreboard
module reg_file_mp #(
    parameter int DATA_WIDTH   = pkg_config::DATA_WIDTH,
    parameter int NUM_REGISTER = pkg_config::NUM_REGISTER,
    parameter int NUM_READ     = pkg_config::NUM_READ_DEF,
    parameter int NUM_WRITE    = pkg_config::NUM_WRITE_DEF,
    parameter int BYPASS       = 1,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_WRITE-1:0]                we_i,
    input  logic [NUM_WRITE-1:0][AW-1:0]        rd_addr_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] rd_i,
    input  logic [NUM_READ-1:0][AW-1:0]         rs_addr_i,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0] rs_o,
    input  logic                                rsv_i,
    input  logic [AW-1:0]                       rsv_addr_i,
    output logic [NUM_READ-1:0]                 busy_o,
    output logic [NUM_REGISTER-1:0]             pending_o
);
    import pkg_config::*;

    logic [DATA_WIDTH-1:0] regs [NUM_REGISTER];
    logic [NUM_WRITE-1:0]  wr_ok;
    logic [NUM_READ-1:0]   byp_hit;

    always_comb begin
        for (int p = 0; p < NUM_WRITE; p++)
            wr_ok[p] = we_i[p] && addr_legal(32'(rd_addr_i[p]), NUM_REGISTER);
    end

    // Later ports overwrite earlier ones in loop order, so the highest index wins a conflict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGISTER; i++) regs[i] <= '0;
        end else begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (wr_ok[p]) regs[rd_addr_i[p]] <= rd_i[p];
            end
        end
    end

    always_comb begin
        rs_o    = '0;
        byp_hit = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if (addr_legal(32'(rs_addr_i[r]), NUM_REGISTER)) begin
                rs_o[r] = regs[rs_addr_i[r]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WRITE; p++) begin
                        if (wr_ok[p] && (rd_addr_i[p] == rs_addr_i[r])) begin
                            rs_o[r]    = rd_i[p];
                            byp_hit[r] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGISTER (NUM_REGISTER),
        .NUM_READ     (NUM_READ),
        .NUM_WRITE    (NUM_WRITE)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_ok_i    (wr_ok),
        .wr_addr_i  (rd_addr_i),
        .rsv_i      (rsv_i),
        .rsv_addr_i (rsv_addr_i),
        .rs_addr_i  (rs_addr_i),
        .byp_hit_i  (byp_hit),
        .busy_o     (busy_o),
        .pending_o  (pending_o)
    );
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the RV32I integer register file.
- Supports a configurable number of read and write ports, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit.
- Sits between decode/issue (reads, reservations) and writeback (writes). Intended for dual-issue / multi-writeback pipeline variants; with NUM_READ=2, NUM_WRITE=1, BYPASS=0 it reduces to the single-issue file.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGISTER, 32, architectural register count; need not be a power of two.
- NUM_READ, 2, number of combinational read ports, 1..8.
- NUM_WRITE, 1, number of synchronous write ports, 1..4.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored data only.
- AW, $clog2(NUM_REGISTER), address width (derived, not to be overridden).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- we_i  in  NUM_WRITE  per-port write enable.
- rd_addr_i  in  NUM_WRITE x AW  per-port destination address.
- rd_i  in  NUM_WRITE x DATA_WIDTH  per-port write data.
- rs_addr_i  in  NUM_READ x AW  per-port source address.
- rs_o  out  NUM_READ x DATA_WIDTH  per-port read data (combinational).
- rsv_i  in  1  reserve request; marks a register pending.
- rsv_addr_i  in  AW  register to reserve.
- busy_o  out  NUM_READ  pending status of each rs_addr_i.
- pending_o  out  NUM_REGISTER  raw scoreboard vector.

Behaviour:
- Reset: on a clk_i edge with rst_i=1, all registers clear to 0 and all pending bits clear to 0; writes and reservations in that cycle are ignored. Reset has priority over everything.
  - Outputs after reset: rs_o = 0 for every address, busy_o = 0, pending_o = 0.
  - A reset arriving mid-sequence discards outstanding reservations with no completion.
- Register x0:
  - Reads as 0.
  - Writes to x0 are dropped.
  - Reservations of x0 are dropped; pending_o[0] is always 0.
- Out-of-range address (>= NUM_REGISTER, possible when the count is not a power of two):
  - Reads return 0 and busy=0.
  - Writes and reservations to it are dropped.
  - X/unknown addresses are not handled specially.
- Write: on the edge, for each port p with we_i[p]=1 and a legal nonzero address, registers[rd_addr_i[p]] <= rd_i[p]. Visible on the stored path one cycle later.
- Write conflict: when several ports write the same address in one cycle, the highest-index port wins; the others are discarded silently.
- Read, zero latency, combinational:
  - BYPASS=1: if any enabled write port targets rs_addr_i[r] (legal, nonzero) in the same cycle, rs_o[r] is that port's data (highest index on conflict). Otherwise rs_o[r] is the stored value.
  - BYPASS=0: rs_o[r] is always the stored value.
- Scoreboard:
  - Set: an accepted reservation sets pending[rsv_addr_i] at the edge.
  - Clear: an accepted write clears pending[rd_addr_i[p]] at the edge. Writing a register that is not pending is legal and leaves it clear.
  - Simultaneous reserve and write to the same register: the reserve wins and pending stays 1, because the new producer supersedes the completing one.
  - Reserving an already pending register is legal; the bit stays 1 (no counting).
- busy_o[r] = pending[rs_addr_i[r]], masked to 0 when:
  - BYPASS=1 and a same-cycle write hits that address, or
  - the address is 0 or out of range.
- No internal stall: issue logic must consume busy_o itself.

Decomposition:
- Package pkg_config gains:
  - REG_AW = $clog2(NUM_REGISTER)
  - typedef reg_addr_t = logic [REG_AW-1:0]
  - typedef reg_data_t = logic [DATA_WIDTH-1:0]
  - NUM_READ_DEF = 2, NUM_WRITE_DEF = 1
- Sub-module reg_scoreboard holds the pending vector, set/clear priority and the busy lookup. Parameters: NUM_REGISTER, NUM_READ, NUM_WRITE. It shares clk_i and rst_i.
- The data array, write-conflict resolution and bypass mux stay in reg_file_mp.

Test Plan:
- Reset: write x5 = 0xDEADBEEF, then assert rst_i for one cycle -> rs_o(x5) = 0, pending_o = 0 on the following cycle.
- x0 handling: write x0 = 0x1234 and reserve x0 -> rs_o(x0) = 0, pending_o[0] = 0.
- Port conflict: NUM_WRITE=2, port0 writes x7 = 0xAAAA0000 and port1 writes x7 = 0x5555FFFF in the same cycle -> next cycle rs_o(x7) = 0x5555FFFF.
- Bypass: with BYPASS=1, write x3 = 0xCAFEF00D while reading x3 in the same cycle -> rs_o = 0xCAFEF00D and busy = 0. With BYPASS=0 the same stimulus -> rs_o = old value (0), then 0xCAFEF00D one cycle later.
- Scoreboard:
  - Reserve x10 -> next cycle busy(x10) = 1.
  - Write x10 = 42 -> next cycle busy(x10) = 0 and rs_o = 42.
  - Reserve and write x10 in the same cycle -> pending[10] remains 1.
- Range: NUM_REGISTER=24, read address 30, write address 30 = 0xFF -> rs_o = 0, no register changes, busy = 0.
